pipeline_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, the XZR
// register number and the packed control-word patterns that drive the pipeline.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_en;
    logic memwb_bubble;
  } ctrl_t;

  // Control words; a flush/bubble bit loads the all-zero NOP into that register.
  localparam ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of the ID
// instruction. XZR never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_uses_rm,
  output logic       load_use
);

  assign load_use = ex_memread && (ex_rd != XZR) &&
                    ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze with
// timeout watchdog, branch squash, load-use stall and a stall-cycle counter.
//
//   state    | meaning
//   RUN      | normal issue; branch / load-use / zero-wait memory handled here
//   MEM_WAIT | data memory busy; pipeline frozen, MEM/WB bubbled, watchdog counting
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rn,
  input  logic [4:0]           id_rm,
  input  logic                 id_uses_rm,
  input  logic                 ex_memread,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_br_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_en,
  output logic                 idex_bubble,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 memwb_bubble,
  output logic                 mem_err,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [WW-1:0] wait_cnt;
  logic          abort_q;
  logic          load_use;
  logic          start_wait, freeze, timeout;
  ctrl_t         ctrl;

  hazard_detect u_hazard (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .id_uses_rm (id_uses_rm),
    .load_use   (load_use)
  );

  // The entry cycle counts as the first wait cycle, so the freeze lasts
  // TIMEOUT cycles in total before the watchdog releases the pipeline.
  assign start_wait = (state_q == RUN) && !abort_q && mem_req && !mem_ready;
  assign timeout    = (state_q == MEM_WAIT) && !mem_ready && (wait_cnt == WAIT_LAST);
  assign freeze     = start_wait || ((state_q == MEM_WAIT) && !mem_ready);

  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_NORMAL;
    case (state_q)
      RUN:      if (start_wait) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready || timeout) state_d = RUN;
      default:  state_d = RUN;
    endcase

    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (freeze) begin
      ctrl = CTRL_FREEZE;
    end else begin
      if (ex_br_taken)   ctrl = CTRL_BRANCH;
      else if (load_use) ctrl = CTRL_LOAD_USE;
      // Aborted access must not write back its stale result.
      if (abort_q) ctrl.memwb_bubble = 1'b1;
    end
  end

  assign {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
          exmem_en, memwb_en, memwb_bubble} = ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      wait_cnt     <= '0;
      abort_q      <= 1'b0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= timeout;
      if (timeout) mem_err <= 1'b1;

      if (start_wait)
        wait_cnt <= WW'(1);
      else if ((state_q == MEM_WAIT) && !mem_ready && !timeout)
        wait_cnt <= wait_cnt + WW'(1);
      else
        wait_cnt <= '0;

      if (!pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end

endmodule
